// File: rtl/pulse_burst_gen.sv
// Burst pulse generator: turns one accepted request into trig_count fixed-width
// high pulses, each followed by a fixed low gap, on a registered output line.
module pulse_burst_gen #(
    parameter int HIGH_LEN = 4,
    parameter int GAP_LEN  = 4,
    parameter int CNT_W    = 8,
    parameter int NUM_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_valid,
    input  logic [NUM_W-1:0] trig_count,
    output logic             trig_ready,
    input  logic             abort,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(HIGH_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] PH_ONE  = CNT_W'(1);
    localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [NUM_W-1:0]   left_q,  left_d;
    logic               pulse_q, busy_q, ready_q, done_q;
    logic               done_d;
    logic               accept;

    // abort takes priority over a same-cycle request, so it blocks acceptance
    assign accept = trig_valid && (state_q == S_IDLE) && !abort;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        left_d  = left_q;
        done_d  = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            phase_d = '0;
            left_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (trig_count != '0) begin
                            state_d = S_HIGH;
                            phase_d = HIGH_LD;
                            left_d  = trig_count - NUM_ONE;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (phase_q == '0) begin
                        state_d = S_GAP;
                        phase_d = GAP_LD;
                    end else begin
                        phase_d = phase_q - PH_ONE;
                    end
                end
                S_GAP: begin
                    if (phase_q != '0) begin
                        phase_d = phase_q - PH_ONE;
                    end else if (left_q != '0) begin
                        state_d = S_HIGH;
                        phase_d = HIGH_LD;
                        left_d  = left_q - NUM_ONE;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = '0;
                    left_d  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and held in flops so the pad
    // line never sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            left_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            left_q  <= left_d;
            pulse_q <= (state_d == S_HIGH);
            busy_q  <= (state_d != S_IDLE);
            ready_q <= (state_d == S_IDLE);
            done_q  <= done_d;
        end
    end

    assign pulse_out  = pulse_q;
    assign busy       = busy_q;
    assign trig_ready = ready_q;
    assign done       = done_q;

endmodule
